dac_mem_loader: RTL and testbench

DAC_MEM_LOADER -- requirements
Module: dac_mem_loader

---
 rtl/signal_types_pkg.sv | 29 ++
 rtl/dac_mem_loader.sv | 200 ++++++++++++++++++++
 tb/tb_dac_mem_loader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/signal_types_pkg.sv
// Shared types for the DAC sample path: the packed sample word, the loader
// FSM state encoding and the maximum-waveform-length derivation.
package signal_types_pkg;

  // One 32-bit word carries both DAC channels, 14 bits each, each padded to 16.
  typedef struct packed {
    logic [1:0]  unused1;
    logic [13:0] ch1;
    logic [1:0]  unused0;
    logic [13:0] ch0;
  } dac_sample_t;

  // Loader states: accept first beat, keep loading, discard overflow, wait for swap.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    PEND  = 2'd3
  } loader_state_t;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 11;

  // Largest waveform that fits a bank while keeping its length representable
  // in an ADDR_WIDTH-bit length field.
  function automatic int unsigned max_len(input int unsigned addr_width);
    return (32'd1 << addr_width) - 32'd1;
  endfunction

endpackage

// File: rtl/dac_mem_loader.sv
// Ping-pong loader for the DAC sample BRAM. Incoming sample beats are written
// into the bank the playback controller is not reading; once a complete
// waveform is in place the banks are swapped, either at the controller's next
// address wrap or immediately when playback is disabled.
module dac_mem_loader
  import signal_types_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int MAX_LEN    = max_len(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic                  s_last_i,
  input  logic                  play_i,
  input  logic                  wrap_i,
  input  logic                  ovf_clr_i,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH:0]   mem_wr_addr_o,
  output logic [31:0]           mem_wr_data_o,
  output logic                  rd_bank_o,
  output logic                  dac_en_o,
  output logic [ADDR_WIDTH-1:0] dac_len_o,
  output logic                  busy_o,
  output logic                  ovf_o
);

  localparam logic [ADDR_WIDTH-1:0] MAX_LEN_W = ADDR_WIDTH'(MAX_LEN);
  localparam logic [ADDR_WIDTH-1:0] ONE_W     = ADDR_WIDTH'(1);

  loader_state_t state_reg, state_next;

  // Beats written so far in the waveform being loaded.
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  // Length of the completed waveform waiting for the bank swap.
  logic [ADDR_WIDTH-1:0] pend_len_reg, pend_len_next;

  logic                  rd_bank_reg;
  logic [ADDR_WIDTH-1:0] dac_len_reg;
  logic                  valid_wave_reg;
  logic                  dac_en_reg;
  logic                  ovf_reg;

  logic                  wr_en_reg;
  logic [ADDR_WIDTH:0]   wr_addr_reg;
  logic [31:0]           wr_data_reg;

  // Decoded per-cycle controls from the FSM.
  logic                  ready_comb;
  logic                  xfer;
  logic                  wr_next;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  ovf_set;
  logic                  swap;
  logic [ADDR_WIDTH-1:0] beat_num;

  dac_sample_t sample;

  assign sample   = dac_sample_t'(s_data_i);
  // Ready is held low while reset is asserted so no beat is lost into a reset.
  assign s_ready_o = ready_comb & ~rst;
  assign xfer      = s_valid_i & s_ready_o;
  // Ordinal (1-based) of a beat accepted in LOAD.
  assign beat_num  = cnt_reg + ONE_W;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-cycle controls.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    pend_len_next = pend_len_reg;
    ready_comb    = 1'b0;
    wr_next       = 1'b0;
    wr_idx        = '0;
    ovf_set       = 1'b0;
    swap          = 1'b0;

    case (state_reg)
      IDLE: begin
        ready_comb = 1'b1;
        if (xfer) begin
          wr_next  = 1'b1;
          wr_idx   = '0;
          cnt_next = ONE_W;
          if (s_last_i) begin
            pend_len_next = ONE_W;
            state_next    = PEND;
          end else if (MAX_LEN_W == ONE_W) begin
            ovf_set       = 1'b1;
            pend_len_next = MAX_LEN_W;
            state_next    = DRAIN;
          end else begin
            state_next = LOAD;
          end
        end
      end

      LOAD: begin
        ready_comb = 1'b1;
        if (xfer) begin
          wr_next  = 1'b1;
          wr_idx   = cnt_reg;
          cnt_next = beat_num;
          if (s_last_i) begin
            // A last beat that lands exactly on MAX_LEN is a clean finish.
            pend_len_next = beat_num;
            state_next    = PEND;
          end else if (beat_num == MAX_LEN_W) begin
            ovf_set       = 1'b1;
            pend_len_next = MAX_LEN_W;
            state_next    = DRAIN;
          end
        end
      end

      DRAIN: begin
        ready_comb = 1'b1;
        if (xfer && s_last_i) begin
          state_next = PEND;
        end
      end

      PEND: begin
        // Swap only at a read-address wrap, or at once if nothing is playing.
        if (wrap_i || !dac_en_reg) begin
          swap       = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Beat counter, pending length, bank select, loop length and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      pend_len_reg   <= '0;
      rd_bank_reg    <= 1'b0;
      dac_len_reg    <= '0;
      valid_wave_reg <= 1'b0;
      dac_en_reg     <= 1'b0;
      ovf_reg        <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      pend_len_reg <= pend_len_next;
      if (swap) begin
        rd_bank_reg    <= ~rd_bank_reg;
        dac_len_reg    <= pend_len_reg;
        valid_wave_reg <= 1'b1;
      end
      dac_en_reg <= play_i & valid_wave_reg;
      // Setting the flag takes priority over a simultaneous clear.
      if (ovf_set) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  // Registered BRAM write port; always targets the bank not being read.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= wr_next;
      if (wr_next) begin
        wr_addr_reg <= {~rd_bank_reg, wr_idx};
        wr_data_reg <= sample;
      end
    end
  end

  assign mem_wr_en_o   = wr_en_reg;
  assign mem_wr_addr_o = wr_addr_reg;
  assign mem_wr_data_o = wr_data_reg;
  assign rd_bank_o     = rd_bank_reg;
  assign dac_en_o      = dac_en_reg;
  assign dac_len_o     = dac_len_reg;
  assign busy_o        = (state_reg != IDLE);
  assign ovf_o         = ovf_reg;

endmodule

// File: tb/tb_dac_mem_loader.sv
// Directed bench for dac_mem_loader: a write scoreboard built from the
// waveform rules (bank opposite the read bank, contiguous indices from 0,
// beats past the length limit dropped) plus literal checks of bank, length,
// enable and overflow at the points the loader is expected to swap.
module tb_dac_mem_loader;

  localparam int AW = 11;
  localparam int ML = 2047;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic          s_last_i;
  logic          play_i;
  logic          wrap_i;
  logic          ovf_clr_i;
  logic          mem_wr_en_o;
  logic [AW:0]   mem_wr_addr_o;
  logic [31:0]   mem_wr_data_o;
  logic          rd_bank_o;
  logic          dac_en_o;
  logic [AW-1:0] dac_len_o;
  logic          busy_o;
  logic          ovf_o;

  int checks = 0;
  int errors = 0;

  // Expected BRAM writes: {address, data}.
  logic [AW+32:0] exp_q[$];
  // Bank the bench believes the controller is reading.
  logic model_rd_bank = 1'b0;

  dac_mem_loader #(.ADDR_WIDTH(AW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_last_i(s_last_i), .play_i(play_i), .wrap_i(wrap_i),
    .ovf_clr_i(ovf_clr_i), .mem_wr_en_o(mem_wr_en_o),
    .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .rd_bank_o(rd_bank_o), .dac_en_o(dac_en_o), .dac_len_o(dac_len_o),
    .busy_o(busy_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Write scoreboard: every write must match the oldest expected one and land
  // in the bank opposite the one being read.
  always @(negedge clk) begin
    if (!rst && mem_wr_en_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", mem_wr_addr_o, mem_wr_data_o);
      end else begin
        logic [AW+32:0] e;
        e = exp_q.pop_front();
        if ({mem_wr_addr_o, mem_wr_data_o} !== e) begin
          errors++;
          $display("FAIL wr_beat: got addr %0h data %0h expected addr %0h data %0h",
                   mem_wr_addr_o, mem_wr_data_o, e[AW+32:32], e[31:0]);
        end else begin
          $display("ok   wr addr %0h data %0h", mem_wr_addr_o, mem_wr_data_o);
        end
      end
      checks++;
      if (mem_wr_addr_o[AW] === rd_bank_o) begin
        errors++;
        $display("FAIL wr_bank: got write bank %0d expected not read bank %0d", mem_wr_addr_o[AW], rd_bank_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until it is accepted (bounded wait).
  task automatic send_beat(input logic [31:0] data, input logic last);
    bit got;
    got = 0;
    s_valid_i = 1'b1;
    s_data_i  = data;
    s_last_i  = last;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (s_ready_o) got = 1;
      tick();
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got no ready expected ready within 50 cycles");
    end
  endtask

  // Beat k (1-based) of a waveform; only beats within the length limit are
  // written, into the bank that is not being read.
  task automatic do_beat(input int k, input logic last, input int gap);
    logic [31:0] d;
    logic [AW-1:0] idx;
    d = $urandom;
    if (k <= ML) begin
      idx = AW'(k - 1);
      exp_q.push_back({~model_rd_bank, idx, d});
    end
    send_beat(d, last);
    for (int g = 0; g < gap; g++) tick();
  endtask

  task automatic wave(input int n, input int max_gap);
    for (int k = 1; k <= n; k++) begin
      do_beat(k, k == n, (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"},   32'(s_ready_o),   32'd0);
    chk({tag, "_busy"},    32'(busy_o),      32'd0);
    chk({tag, "_rd_bank"}, 32'(rd_bank_o),   32'd0);
    chk({tag, "_dac_len"}, 32'(dac_len_o),   32'd0);
    chk({tag, "_dac_en"},  32'(dac_en_o),    32'd0);
    chk({tag, "_ovf"},     32'(ovf_o),       32'd0);
    chk({tag, "_wr_en"},   32'(mem_wr_en_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; s_data_i = '0; s_valid_i = 1'b0; s_last_i = 1'b0;
    play_i = 1'b0; wrap_i = 1'b0; ovf_clr_i = 1'b0;
    tick(); tick(); tick();
    chk_reset_values("rst");
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(s_ready_o), 32'd1);

    // Idle playback, 4-beat waveform: immediate swap.
    wave(4, 0);
    @(negedge clk);
    chk("w4_pend_busy",  32'(busy_o),    32'd1);
    chk("w4_pend_ready", 32'(s_ready_o), 32'd0);
    chk("w4_pre_bank",   32'(rd_bank_o), 32'd0);
    tick();
    model_rd_bank = 1'b1;
    chk("w4_rd_bank", 32'(rd_bank_o), 32'd1);
    chk("w4_dac_len", 32'(dac_len_o), 32'd4);
    chk("w4_idle",    32'(busy_o),    32'd0);
    play_i = 1'b1;
    chk("w4_en_before", 32'(dac_en_o), 32'd0);
    tick();
    chk("w4_en_after", 32'(dac_en_o), 32'd1);

    // Playing: 3-beat waveform whose last beat coincides with a wrap pulse.
    do_beat(1, 1'b0, 0);
    do_beat(2, 1'b0, 0);
    wrap_i = 1'b1;
    do_beat(3, 1'b1, 0);
    wrap_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("w3_hold_bank", 32'(rd_bank_o), 32'd1);
    chk("w3_hold_len",  32'(dac_len_o), 32'd4);
    chk("w3_hold_busy", 32'(busy_o),    32'd1);
    wrap_i = 1'b1;
    tick();
    wrap_i = 1'b0;
    model_rd_bank = 1'b0;
    chk("w3_rd_bank", 32'(rd_bank_o), 32'd0);
    chk("w3_dac_len", 32'(dac_len_o), 32'd3);
    chk("w3_idle",    32'(busy_o),    32'd0);

    // Single beat; valid held high through PEND; play dropped to force swap.
    wave(1, 0);
    s_valid_i = 1'b1;
    s_data_i  = 32'hdead_beef;
    for (int i = 0; i < 5; i++) begin
      chk("w1_pend_ready", 32'(s_ready_o), 32'd0);
      tick();
    end
    s_valid_i = 1'b0;
    play_i = 1'b0;
    chk("w1_en_still", 32'(dac_en_o), 32'd1);
    tick();
    chk("w1_en_fell",   32'(dac_en_o),  32'd0);
    chk("w1_no_swap",   32'(rd_bank_o), 32'd0);
    tick();
    model_rd_bank = 1'b1;
    chk("w1_rd_bank", 32'(rd_bank_o), 32'd1);
    chk("w1_dac_len", 32'(dac_len_o), 32'd1);

    // Overflow: 2050 beats without last, then last. Clear held at the set.
    for (int k = 1; k <= ML - 1; k++) do_beat(k, 1'b0, 0);
    chk("ovf_before", 32'(ovf_o), 32'd0);
    ovf_clr_i = 1'b1;
    do_beat(ML, 1'b0, 0);
    chk("ovf_set_wins", 32'(ovf_o), 32'd1);
    ovf_clr_i = 1'b0;
    chk("ovf_drain_busy", 32'(busy_o), 32'd1);
    for (int k = ML + 1; k <= 2050; k++) do_beat(k, 1'b0, 0);
    do_beat(2051, 1'b1, 0);
    tick();
    model_rd_bank = 1'b0;
    chk("ovf_rd_bank", 32'(rd_bank_o), 32'd0);
    chk("ovf_dac_len", 32'(dac_len_o), 32'd2047);
    chk("ovf_sticky",  32'(ovf_o),     32'd1);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    chk("ovf_cleared", 32'(ovf_o), 32'd0);

    // Last beat exactly at the length limit: no overflow.
    wave(ML, 0);
    tick();
    model_rd_bank = 1'b1;
    chk("max_rd_bank", 32'(rd_bank_o), 32'd1);
    chk("max_dac_len", 32'(dac_len_o), 32'd2047);
    chk("max_no_ovf",  32'(ovf_o),     32'd0);

    // Reset in the middle of a load abandons it.
    do_beat(1, 1'b0, 0);
    do_beat(2, 1'b0, 0);
    tick();
    rst = 1'b1;
    tick(); tick();
    chk_reset_values("midrst");
    rst = 1'b0;
    model_rd_bank = 1'b0;
    tick();
    wave(4, 0);
    tick();
    model_rd_bank = 1'b1;
    chk("post_rst_bank", 32'(rd_bank_o), 32'd1);
    chk("post_rst_len",  32'(dac_len_o), 32'd4);

    // 8 beats with random valid gaps.
    wave(8, 3);
    tick();
    model_rd_bank = 1'b0;
    chk("gap_rd_bank", 32'(rd_bank_o), 32'd0);
    chk("gap_dac_len", 32'(dac_len_o), 32'd8);

    tick(); tick();
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
